mem_bus_arb: RTL and testbench
==============================

Name: mem_bus_arb

Overview:
Two-master, single-slave arbiter that shares the core's one memory port between the IFU (instruction fetch, read-only) and the LSU (loads/stores). It holds one outstanding transaction at a time and sequences it through a request/response FSM. It suppresses IFU fetch responses made stale by an EXU jump redirect. It sits between ifu/lsu and the memory/bus wrapper.

Parameters:
ADDR_WIDTH, 32, address width of all request channels
DATA_WIDTH, 32, data width; DATA_WIDTH/8 byte-mask bits
STREAK_MAX, 4, max consecutive LSU grants while IFU is pending before IFU is forced once (fixed-priority mode only)

Ports:
i_sys_clk  in  1  system clock
i_sys_rst_n  in  1  asynchronous active-low reset
i_exu_jmp_en  in  1  EXU redirect; in-flight IFU fetch becomes stale
i_ifu_req_valid  in  1  IFU fetch request
o_ifu_req_ready  out  1  IFU request accepted this cycle
i_ifu_req_addr  in  ADDR_WIDTH  fetch PC
o_ifu_resp_valid  out  1  instruction returned (1-cycle pulse)
o_ifu_resp_data  out  DATA_WIDTH  instruction word
i_lsu_req_valid  in  1  LSU request
o_lsu_req_ready  out  1  LSU request accepted this cycle
i_lsu_req_addr  in  ADDR_WIDTH  load/store address
i_lsu_req_wr_en  in  1  1 = store, 0 = load
i_lsu_req_wr_data  in  DATA_WIDTH  store data
i_lsu_req_wr_mask  in  DATA_WIDTH/8  store byte enables
o_lsu_resp_valid  out  1  load data / store ack (1-cycle pulse)
o_lsu_resp_data  out  DATA_WIDTH  load data; 0 for stores
o_mem_req_valid  out  1  memory request valid
i_mem_req_ready  in  1  memory accepts request
o_mem_req_addr  out  ADDR_WIDTH  registered address
o_mem_req_wr_en  out  1  registered write enable (0 for IFU)
o_mem_req_wr_data  out  DATA_WIDTH  registered store data
o_mem_req_wr_mask  out  DATA_WIDTH/8  registered mask (0 for IFU)
i_mem_resp_valid  in  1  memory response valid
i_mem_resp_data  in  DATA_WIDTH  memory read data

Behaviour:
- Reset: state IDLE; owner, drop flag, streak counter, and all request/response registers = 0. Every output = 0.
- FSM states:
  - IDLE: evaluate grant. On grant, assert o_<owner>_req_ready combinationally (one cycle), latch the owner's fields into the mem request registers, then go to REQ.
  - REQ: o_mem_req_valid = 1 with stable registered fields. When i_mem_req_ready = 1, go to WAIT.
  - WAIT: on i_mem_resp_valid, register the data and pulse o_<owner>_resp_valid for the next cycle. Go to IDLE, which may grant again in that same cycle.
- A request is accepted only when valid && ready. Both ready outputs are 0 outside IDLE. They are never both 1.
- Minimum latency, accept to response pulse: 3 cycles (IDLE to REQ to WAIT, memory responds in the first WAIT cycle, response on the next cycle).
- Fixed priority: LSU > IFU.
  - streak counts consecutive LSU grants made while i_ifu_req_valid = 1; it saturates at STREAK_MAX.
  - When streak == STREAK_MAX and both requesters are valid, IFU is granted and streak clears.
  - streak also clears on any IFU grant and on any LSU grant with the IFU idle.
- Jump handling:
  - i_exu_jmp_en in IDLE forces o_ifu_req_ready = 0 that cycle; the LSU may still be granted.
  - i_exu_jmp_en while owner = IFU in REQ or WAIT sets the drop flag. The memory transaction still completes, but o_ifu_resp_valid is suppressed. Drop clears on return to IDLE.
  - LSU transactions are never dropped.
- Simultaneous i_mem_resp_valid and i_exu_jmp_en in WAIT (owner IFU): the response is dropped.
- i_mem_resp_valid outside WAIT is ignored.
- Async reset mid-transaction returns to IDLE immediately. The outstanding transaction is abandoned and the memory is reset concurrently.

Optional Feature:
MEM_ARB_RR_EN
- Defined: round-robin arbitration. When both requesters are valid, grant the one not granted last; a last-grant bit (reset = IFU) replaces the streak counter, and STREAK_MAX is unused.
- Undefined: fixed LSU priority with the streak guard described above.
- Jump/drop behaviour is identical in both modes.

Test Plan:
- IFU-only fetch: addr 0x8000_0000, memory ready immediately, returns 0x0000_0013 on the first WAIT cycle -> o_ifu_resp_valid pulse with 0x0000_0013 exactly 3 cycles after accept; o_mem_req_wr_en = 0, mask = 0.
- Simultaneous requests: IFU 0x8000_0004 and LSU store 0x9000_0000, data 0xDEAD_BEEF, mask 0xF -> LSU granted first and the mem port shows the store fields; IFU granted in the IDLE cycle after the LSU ack; o_lsu_resp_data = 0.
- Starvation guard (RR off, STREAK_MAX = 4): LSU and IFU held valid continuously -> grant order LSU, LSU, LSU, LSU, IFU, LSU...
- Jump drop: IFU fetch 0x8000_0008 in WAIT, i_exu_jmp_en pulsed, memory returns 0x1234_5678 two cycles later -> no o_ifu_resp_valid, FSM back in IDLE; the next fetch to 0x9000_0000 completes normally.
- Backpressure: i_mem_req_ready held 0 for 5 cycles -> o_mem_req_valid stays 1 with unchanged addr/data, both readies stay 0; the transaction proceeds on the first ready cycle.
- Reset in WAIT: drop i_sys_rst_n for one cycle while an LSU load is outstanding -> all outputs 0 immediately, no o_lsu_resp_valid afterwards, IDLE accepts a new request after reset release.

Source files
------------

// File: rtl/mem_bus_arb.sv
// mem_bus_arb: shares one memory port between IFU fetches and LSU loads/stores, one transaction at a time.
// Define MEM_ARB_RR_EN for round-robin arbitration; default is LSU priority with an IFU starvation guard.
module mem_bus_arb #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int STREAK_MAX = 4
) (
    input  logic                    i_sys_clk,
    input  logic                    i_sys_rst_n,
    input  logic                    i_exu_jmp_en,
    input  logic                    i_ifu_req_valid,
    output logic                    o_ifu_req_ready,
    input  logic [ADDR_WIDTH-1:0]   i_ifu_req_addr,
    output logic                    o_ifu_resp_valid,
    output logic [DATA_WIDTH-1:0]   o_ifu_resp_data,
    input  logic                    i_lsu_req_valid,
    output logic                    o_lsu_req_ready,
    input  logic [ADDR_WIDTH-1:0]   i_lsu_req_addr,
    input  logic                    i_lsu_req_wr_en,
    input  logic [DATA_WIDTH-1:0]   i_lsu_req_wr_data,
    input  logic [DATA_WIDTH/8-1:0] i_lsu_req_wr_mask,
    output logic                    o_lsu_resp_valid,
    output logic [DATA_WIDTH-1:0]   o_lsu_resp_data,
    output logic                    o_mem_req_valid,
    input  logic                    i_mem_req_ready,
    output logic [ADDR_WIDTH-1:0]   o_mem_req_addr,
    output logic                    o_mem_req_wr_en,
    output logic [DATA_WIDTH-1:0]   o_mem_req_wr_data,
    output logic [DATA_WIDTH/8-1:0] o_mem_req_wr_mask,
    input  logic                    i_mem_resp_valid,
    input  logic [DATA_WIDTH-1:0]   i_mem_resp_data
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    state_t                  state, state_nxt;
    logic                    owner;
    logic                    drop;
    logic                    ifu_ok;
    logic                    pick_ifu;
    logic                    gnt_ifu, gnt_lsu;
    logic                    ifu_rv, lsu_rv;
    logic [DATA_WIDTH-1:0]   resp_data;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic                    wr_en_q;
    logic [DATA_WIDTH-1:0]   wr_data_q;
    logic [DATA_WIDTH/8-1:0] wr_mask_q;

`ifdef MEM_ARB_RR_EN
    logic last_lsu;
    assign pick_ifu = last_lsu;
    always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
        if (!i_sys_rst_n)
            last_lsu <= 1'b0;
        else if (gnt_ifu || gnt_lsu)
            last_lsu <= gnt_lsu;
    end
`else
    localparam int SW = $clog2(STREAK_MAX + 1);
    logic [SW-1:0] streak;
    assign pick_ifu = (streak == SW'(STREAK_MAX));
    // streak only survives LSU grants that kept a pending IFU waiting
    always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
        if (!i_sys_rst_n)
            streak <= '0;
        else if (gnt_ifu)
            streak <= '0;
        else if (gnt_lsu)
            streak <= !i_ifu_req_valid ? '0 : pick_ifu ? streak : streak + SW'(1);
    end
`endif

    always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
        if (!i_sys_rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        gnt_ifu   = 1'b0;
        gnt_lsu   = 1'b0;
        ifu_ok    = i_ifu_req_valid && !i_exu_jmp_en;
        case (state)
            IDLE: begin
                gnt_ifu = ifu_ok && (!i_lsu_req_valid || pick_ifu);
                gnt_lsu = i_lsu_req_valid && !gnt_ifu;
                state_nxt = (gnt_ifu || gnt_lsu) ? REQ : IDLE;
            end
            REQ:     state_nxt = i_mem_req_ready ? WAIT : REQ;
            WAIT:    state_nxt = i_mem_resp_valid ? IDLE : WAIT;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
        if (!i_sys_rst_n) begin
            owner     <= 1'b0;
            drop      <= 1'b0;
            ifu_rv    <= 1'b0;
            lsu_rv    <= 1'b0;
            resp_data <= '0;
            addr_q    <= '0;
            wr_en_q   <= 1'b0;
            wr_data_q <= '0;
            wr_mask_q <= '0;
        end else begin
            ifu_rv <= 1'b0;
            lsu_rv <= 1'b0;
            if (gnt_ifu) begin
                owner     <= 1'b0;
                addr_q    <= i_ifu_req_addr;
                wr_en_q   <= 1'b0;
                wr_data_q <= '0;
                wr_mask_q <= '0;
            end else if (gnt_lsu) begin
                owner     <= 1'b1;
                addr_q    <= i_lsu_req_addr;
                wr_en_q   <= i_lsu_req_wr_en;
                wr_data_q <= i_lsu_req_wr_data;
                wr_mask_q <= i_lsu_req_wr_mask;
            end
            // a jump landing on the response cycle itself must also drop the fetch
            if (state == WAIT && i_mem_resp_valid) begin
                resp_data <= (owner && wr_en_q) ? '0 : i_mem_resp_data;
                ifu_rv    <= !owner && !drop && !i_exu_jmp_en;
                lsu_rv    <= owner;
            end
            drop <= (state_nxt == IDLE) ? 1'b0 : drop || (state != IDLE && !owner && i_exu_jmp_en);
        end
    end

    assign o_ifu_req_ready   = gnt_ifu && i_sys_rst_n;
    assign o_lsu_req_ready   = gnt_lsu && i_sys_rst_n;
    assign o_ifu_resp_valid  = ifu_rv;
    assign o_ifu_resp_data   = resp_data;
    assign o_lsu_resp_valid  = lsu_rv;
    assign o_lsu_resp_data   = resp_data;
    assign o_mem_req_valid   = (state == REQ);
    assign o_mem_req_addr    = addr_q;
    assign o_mem_req_wr_en   = wr_en_q;
    assign o_mem_req_wr_data = wr_data_q;
    assign o_mem_req_wr_mask = wr_mask_q;
endmodule

// File: tb/tb_mem_bus_arb.sv
// tb_mem_bus_arb: scenario tasks with a response scoreboard for mem_bus_arb (default fixed-priority build).
module tb_mem_bus_arb;
    logic        i_sys_clk = 1'b0;
    logic        i_sys_rst_n = 1'b0;
    logic        i_exu_jmp_en = 1'b0;
    logic        i_ifu_req_valid = 1'b0;
    logic        o_ifu_req_ready;
    logic [31:0] i_ifu_req_addr = '0;
    logic        o_ifu_resp_valid;
    logic [31:0] o_ifu_resp_data;
    logic        i_lsu_req_valid = 1'b0;
    logic        o_lsu_req_ready;
    logic [31:0] i_lsu_req_addr = '0;
    logic        i_lsu_req_wr_en = 1'b0;
    logic [31:0] i_lsu_req_wr_data = '0;
    logic [3:0]  i_lsu_req_wr_mask = '0;
    logic        o_lsu_resp_valid;
    logic [31:0] o_lsu_resp_data;
    logic        o_mem_req_valid;
    logic        i_mem_req_ready = 1'b0;
    logic [31:0] o_mem_req_addr;
    logic        o_mem_req_wr_en;
    logic [31:0] o_mem_req_wr_data;
    logic [3:0]  o_mem_req_wr_mask;
    logic        i_mem_resp_valid = 1'b0;
    logic [31:0] i_mem_resp_data = '0;

    typedef struct packed {logic lsu; logic [31:0] data;} exp_t;
    exp_t exp_q[$];
    exp_t mon_e;
    int errors = 0;
    int checks = 0;

    mem_bus_arb dut (
        .i_sys_clk(i_sys_clk), .i_sys_rst_n(i_sys_rst_n), .i_exu_jmp_en(i_exu_jmp_en),
        .i_ifu_req_valid(i_ifu_req_valid), .o_ifu_req_ready(o_ifu_req_ready), .i_ifu_req_addr(i_ifu_req_addr),
        .o_ifu_resp_valid(o_ifu_resp_valid), .o_ifu_resp_data(o_ifu_resp_data),
        .i_lsu_req_valid(i_lsu_req_valid), .o_lsu_req_ready(o_lsu_req_ready), .i_lsu_req_addr(i_lsu_req_addr),
        .i_lsu_req_wr_en(i_lsu_req_wr_en), .i_lsu_req_wr_data(i_lsu_req_wr_data), .i_lsu_req_wr_mask(i_lsu_req_wr_mask),
        .o_lsu_resp_valid(o_lsu_resp_valid), .o_lsu_resp_data(o_lsu_resp_data),
        .o_mem_req_valid(o_mem_req_valid), .i_mem_req_ready(i_mem_req_ready), .o_mem_req_addr(o_mem_req_addr),
        .o_mem_req_wr_en(o_mem_req_wr_en), .o_mem_req_wr_data(o_mem_req_wr_data), .o_mem_req_wr_mask(o_mem_req_wr_mask),
        .i_mem_resp_valid(i_mem_resp_valid), .i_mem_resp_data(i_mem_resp_data)
    );

    always #5 i_sys_clk = ~i_sys_clk;

    initial begin
        #2_000_000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    // every response pulse must match the oldest outstanding expectation
    always @(negedge i_sys_clk) begin
        if (o_ifu_resp_valid || o_lsu_resp_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL resp_unexpected got ifu_v=%b lsu_v=%b ifu_d=%h lsu_d=%h expected no response",
                         o_ifu_resp_valid, o_lsu_resp_valid, o_ifu_resp_data, o_lsu_resp_data);
            end else begin
                mon_e = exp_q.pop_front();
                if ({o_lsu_resp_valid, o_ifu_resp_valid, o_lsu_resp_valid ? o_lsu_resp_data : o_ifu_resp_data}
                    !== {mon_e.lsu, !mon_e.lsu, mon_e.data}) begin
                    errors++;
                    $display("FAIL resp_match got lsu_v=%b ifu_v=%b data=%h expected lsu=%b data=%h",
                             o_lsu_resp_valid, o_ifu_resp_valid,
                             o_lsu_resp_valid ? o_lsu_resp_data : o_ifu_resp_data, mon_e.lsu, mon_e.data);
                end
            end
        end
    end

    function automatic logic [137:0] outs();
        return {o_ifu_req_ready, o_ifu_resp_valid, o_ifu_resp_data, o_lsu_req_ready, o_lsu_resp_valid,
                o_lsu_resp_data, o_mem_req_valid, o_mem_req_addr, o_mem_req_wr_en, o_mem_req_wr_data,
                o_mem_req_wr_mask};
    endfunction

    task automatic step();
        @(posedge i_sys_clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge i_sys_clk);
    endtask

    // waits for the request phase, stalls, accepts, then answers in the first WAIT cycle
    task automatic mem_serve(input logic [31:0] rdata, input int stall);
        int n = 0;
        i_mem_req_ready = 1'b0;
        while (!o_mem_req_valid && n < 20) begin
            step();
            n++;
        end
        if (!o_mem_req_valid) begin
            checks++;
            errors++;
            $display("FAIL mem_req_timeout got valid=0 expected valid=1 within 20 cycles");
            return;
        end
        repeat (stall) step();
        i_mem_req_ready = 1'b1;
        step();
        i_mem_req_ready = 1'b0;
        i_mem_resp_valid = 1'b1;
        i_mem_resp_data = rdata;
        step();
        i_mem_resp_valid = 1'b0;
    endtask

    task automatic check_drained(input string name);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drained got %0d pending expected 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        i_sys_rst_n = 1'b0;
        repeat (2) step();
        at_neg();
        checks++;
        if (outs() !== '0) begin
            errors++;
            $display("FAIL reset_outputs got %h expected 0", outs());
        end
        step();
        i_sys_rst_n = 1'b1;
        step();
    endtask

    task automatic test_ifu_fetch();
        i_ifu_req_valid = 1'b1;
        i_ifu_req_addr = 32'h8000_0000;
        exp_q.push_back('{lsu: 1'b0, data: 32'h0000_0013});
        at_neg();
        checks++;
        if ({o_ifu_req_ready, o_lsu_req_ready} !== 2'b10) begin
            errors++;
            $display("FAIL fetch_ready got %b expected 10", {o_ifu_req_ready, o_lsu_req_ready});
        end
        step();
        i_ifu_req_valid = 1'b0;
        at_neg();
        checks++;
        if ({o_mem_req_valid, o_mem_req_addr, o_mem_req_wr_en, o_mem_req_wr_mask} !== {1'b1, 32'h8000_0000, 1'b0, 4'h0}) begin
            errors++;
            $display("FAIL fetch_mem_req got v=%b a=%h we=%b m=%h expected 1 80000000 0 0",
                     o_mem_req_valid, o_mem_req_addr, o_mem_req_wr_en, o_mem_req_wr_mask);
        end
        mem_serve(32'h0000_0013, 0);
        at_neg();
        checks++;
        if ({o_ifu_resp_valid, o_ifu_resp_data} !== {1'b1, 32'h0000_0013}) begin
            errors++;
            $display("FAIL fetch_latency got v=%b d=%h expected 1 00000013 three cycles after accept",
                     o_ifu_resp_valid, o_ifu_resp_data);
        end
        step();
        check_drained("fetch");
        at_neg();
        checks++;
        if (o_ifu_resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL fetch_pulse got v=%b expected 0", o_ifu_resp_valid);
        end
        step();
    endtask

    task automatic test_simultaneous();
        i_ifu_req_valid = 1'b1;
        i_ifu_req_addr = 32'h8000_0004;
        i_lsu_req_valid = 1'b1;
        i_lsu_req_addr = 32'h9000_0000;
        i_lsu_req_wr_en = 1'b1;
        i_lsu_req_wr_data = 32'hDEAD_BEEF;
        i_lsu_req_wr_mask = 4'hF;
        exp_q.push_back('{lsu: 1'b1, data: 32'h0});
        exp_q.push_back('{lsu: 1'b0, data: 32'h0010_0093});
        at_neg();
        checks++;
        if ({o_ifu_req_ready, o_lsu_req_ready} !== 2'b01) begin
            errors++;
            $display("FAIL simul_lsu_first got %b expected 01", {o_ifu_req_ready, o_lsu_req_ready});
        end
        step();
        i_lsu_req_valid = 1'b0;
        at_neg();
        checks++;
        if ({o_mem_req_addr, o_mem_req_wr_en, o_mem_req_wr_data, o_mem_req_wr_mask}
            !== {32'h9000_0000, 1'b1, 32'hDEAD_BEEF, 4'hF}) begin
            errors++;
            $display("FAIL simul_store_fields got a=%h we=%b d=%h m=%h expected 90000000 1 deadbeef f",
                     o_mem_req_addr, o_mem_req_wr_en, o_mem_req_wr_data, o_mem_req_wr_mask);
        end
        mem_serve(32'h5555_5555, 0);
        at_neg();
        checks++;
        if ({o_lsu_resp_valid, o_ifu_req_ready} !== 2'b11) begin
            errors++;
            $display("FAIL simul_ifu_next got lsu_v=%b ifu_rdy=%b expected 1 1", o_lsu_resp_valid, o_ifu_req_ready);
        end
        step();
        i_ifu_req_valid = 1'b0;
        at_neg();
        checks++;
        if ({o_mem_req_addr, o_mem_req_wr_en, o_mem_req_wr_mask} !== {32'h8000_0004, 1'b0, 4'h0}) begin
            errors++;
            $display("FAIL simul_ifu_fields got a=%h we=%b m=%h expected 80000004 0 0",
                     o_mem_req_addr, o_mem_req_wr_en, o_mem_req_wr_mask);
        end
        mem_serve(32'h0010_0093, 0);
        step();
        check_drained("simul");
    endtask

    task automatic test_starvation();
        logic exp_lsu [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        i_ifu_req_valid = 1'b1;
        i_ifu_req_addr = 32'h8000_0010;
        i_lsu_req_valid = 1'b1;
        i_lsu_req_addr = 32'h9000_0010;
        i_lsu_req_wr_en = 1'b0;
        for (int i = 0; i < 6; i++) begin
            at_neg();
            checks++;
            if ({o_lsu_req_ready, o_ifu_req_ready} !== {exp_lsu[i], !exp_lsu[i]}) begin
                errors++;
                $display("FAIL starve_grant%0d got lsu=%b ifu=%b expected lsu=%b ifu=%b",
                         i, o_lsu_req_ready, o_ifu_req_ready, exp_lsu[i], !exp_lsu[i]);
            end
            exp_q.push_back('{lsu: exp_lsu[i], data: 32'hC000_0000 + i});
            step();
            at_neg();
            checks++;
            if (o_mem_req_addr !== (exp_lsu[i] ? 32'h9000_0010 : 32'h8000_0010)) begin
                errors++;
                $display("FAIL starve_addr%0d got %h expected %h", i, o_mem_req_addr,
                         exp_lsu[i] ? 32'h9000_0010 : 32'h8000_0010);
            end
            mem_serve(32'hC000_0000 + i, 0);
        end
        i_ifu_req_valid = 1'b0;
        i_lsu_req_valid = 1'b0;
        step();
        check_drained("starve");
    endtask

    task automatic test_jump();
        i_ifu_req_valid = 1'b1;
        i_ifu_req_addr = 32'h8000_0008;
        i_exu_jmp_en = 1'b1;
        at_neg();
        checks++;
        if (o_ifu_req_ready !== 1'b0) begin
            errors++;
            $display("FAIL jump_idle_block got ready=%b expected 0", o_ifu_req_ready);
        end
        step();
        i_exu_jmp_en = 1'b0;
        at_neg();
        checks++;
        if (o_ifu_req_ready !== 1'b1) begin
            errors++;
            $display("FAIL jump_idle_release got ready=%b expected 1", o_ifu_req_ready);
        end
        step();
        i_ifu_req_valid = 1'b0;
        i_mem_req_ready = 1'b1;
        step();
        i_mem_req_ready = 1'b0;
        i_exu_jmp_en = 1'b1;
        step();
        i_exu_jmp_en = 1'b0;
        step();
        i_mem_resp_valid = 1'b1;
        i_mem_resp_data = 32'h1234_5678;
        step();
        i_mem_resp_valid = 1'b0;
        at_neg();
        checks++;
        if ({o_ifu_resp_valid, o_mem_req_valid} !== 2'b00) begin
            errors++;
            $display("FAIL jump_drop got resp_v=%b mem_v=%b expected 0 0", o_ifu_resp_valid, o_mem_req_valid);
        end
        step();
        i_ifu_req_valid = 1'b1;
        i_ifu_req_addr = 32'h9000_0000;
        exp_q.push_back('{lsu: 1'b0, data: 32'hCAFE_0001});
        at_neg();
        checks++;
        if (o_ifu_req_ready !== 1'b1) begin
            errors++;
            $display("FAIL jump_next_accept got ready=%b expected 1", o_ifu_req_ready);
        end
        step();
        i_ifu_req_valid = 1'b0;
        mem_serve(32'hCAFE_0001, 0);
        step();
        check_drained("jump_next");
        i_ifu_req_valid = 1'b1;
        i_ifu_req_addr = 32'h8000_0020;
        step();
        i_ifu_req_valid = 1'b0;
        i_mem_req_ready = 1'b1;
        step();
        i_mem_req_ready = 1'b0;
        i_mem_resp_valid = 1'b1;
        i_mem_resp_data = 32'h0BAD_0BAD;
        i_exu_jmp_en = 1'b1;
        step();
        i_mem_resp_valid = 1'b0;
        i_exu_jmp_en = 1'b0;
        at_neg();
        checks++;
        if (o_ifu_resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL jump_same_cycle got resp_v=%b expected 0", o_ifu_resp_valid);
        end
        step();
    endtask

    task automatic test_backpressure();
        i_ifu_req_valid = 1'b1;
        i_ifu_req_addr = 32'h8000_0030;
        i_lsu_req_valid = 1'b1;
        i_lsu_req_addr = 32'hA000_0000;
        i_lsu_req_wr_en = 1'b1;
        i_lsu_req_wr_data = 32'h1122_3344;
        i_lsu_req_wr_mask = 4'h3;
        at_neg();
        checks++;
        if ({o_lsu_req_ready, o_ifu_req_ready} !== 2'b10) begin
            errors++;
            $display("FAIL bp_grant got lsu=%b ifu=%b expected 1 0", o_lsu_req_ready, o_ifu_req_ready);
        end
        step();
        i_lsu_req_valid = 1'b0;
        i_lsu_req_addr = 32'hFFFF_FFFF;
        i_lsu_req_wr_data = 32'hFFFF_FFFF;
        for (int k = 0; k < 5; k++) begin
            at_neg();
            checks++;
            if ({o_mem_req_valid, o_mem_req_addr, o_mem_req_wr_data, o_mem_req_wr_mask, o_ifu_req_ready, o_lsu_req_ready}
                !== {1'b1, 32'hA000_0000, 32'h1122_3344, 4'h3, 2'b00}) begin
                errors++;
                $display("FAIL bp_stall%0d got v=%b a=%h d=%h m=%h rdy=%b%b expected 1 a0000000 11223344 3 00",
                         k, o_mem_req_valid, o_mem_req_addr, o_mem_req_wr_data, o_mem_req_wr_mask,
                         o_ifu_req_ready, o_lsu_req_ready);
            end
            step();
        end
        i_mem_req_ready = 1'b1;
        step();
        i_mem_req_ready = 1'b0;
        i_ifu_req_valid = 1'b0;
        at_neg();
        checks++;
        if (o_mem_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_proceed got v=%b expected 0", o_mem_req_valid);
        end
        exp_q.push_back('{lsu: 1'b1, data: 32'h0});
        step();
        i_mem_resp_valid = 1'b1;
        i_mem_resp_data = 32'h7777_7777;
        step();
        i_mem_resp_valid = 1'b0;
        step();
        check_drained("bp");
    endtask

    task automatic test_reset_in_wait();
        i_lsu_req_valid = 1'b1;
        i_lsu_req_addr = 32'hB000_0000;
        i_lsu_req_wr_en = 1'b0;
        step();
        i_lsu_req_valid = 1'b0;
        i_mem_req_ready = 1'b1;
        step();
        i_mem_req_ready = 1'b0;
        i_sys_rst_n = 1'b0;
        #1;
        checks++;
        if (outs() !== '0) begin
            errors++;
            $display("FAIL rst_wait_outputs got %h expected 0", outs());
        end
        step();
        i_sys_rst_n = 1'b1;
        i_mem_resp_valid = 1'b1;
        i_mem_resp_data = 32'h0000_0099;
        step();
        i_mem_resp_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            at_neg();
            checks++;
            if (o_lsu_resp_valid !== 1'b0) begin
                errors++;
                $display("FAIL rst_wait_no_resp%0d got v=%b expected 0", k, o_lsu_resp_valid);
            end
            step();
        end
        i_lsu_req_valid = 1'b1;
        i_lsu_req_addr = 32'hB000_0004;
        exp_q.push_back('{lsu: 1'b1, data: 32'h0BAD_F00D});
        at_neg();
        checks++;
        if (o_lsu_req_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_wait_accept got ready=%b expected 1", o_lsu_req_ready);
        end
        step();
        i_lsu_req_valid = 1'b0;
        mem_serve(32'h0BAD_F00D, 0);
        step();
        check_drained("rst_wait");
    endtask

    initial begin
        test_reset();
        test_ifu_fetch();
        test_simultaneous();
        test_starvation();
        test_jump();
        test_backpressure();
        test_reset_in_wait();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
